// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI word width, bit-counter width and master state encoding
package spi_pkg;

    localparam int SPI_WORD_W    = 16;
    localparam int SPI_BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } spi_mst_state_t;

    // Largest of the three phase lengths; sizes the shared phase counter.
    function automatic int spi_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_16_if.sv
// rtl/spi_master_16_if.sv - host handshake and SPI pin bundle for spi_master_16
// master modport: START/TX_DATA/MISO in; BUSY/DONE/RX_DATA/SCLK/CHIP_SELECT/MOSI out.
// slave modport: the opposite view, for the host and the attached slave.
interface spi_master_16_if;
    import spi_pkg::*;

    logic                  START;
    logic [SPI_WORD_W-1:0] TX_DATA;
    logic                  BUSY;
    logic                  DONE;
    logic [SPI_WORD_W-1:0] RX_DATA;
    logic                  SCLK;
    logic                  CHIP_SELECT;
    logic                  MOSI;
    logic                  MISO;

    modport master (
        input  START, TX_DATA, MISO,
        output BUSY, DONE, RX_DATA, SCLK, CHIP_SELECT, MOSI
    );

    modport slave (
        output START, TX_DATA, MISO,
        input  BUSY, DONE, RX_DATA, SCLK, CHIP_SELECT, MOSI
    );

endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - loadable down-counter giving a one-cycle phase_end strobe
// Ports: CLK, RESET (sync, active-high), load/load_val (start an N-cycle phase),
// phase_end (high during the Nth cycle after the load).
module spi_clk_div #(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         phase_end
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Counting N..1 means the cycle showing 1 is the last one of the phase.
    assign phase_end = (cnt_q == W'(1));

endmodule

// File: rtl/spi_master_16.sv
// rtl/spi_master_16.sv - mode-0 MSB-first 16-bit SPI master
// Ports: CLK, RESET (sync, active-high), bus (spi_master_16_if.master):
//   START/TX_DATA request a word, BUSY/DONE/RX_DATA report it,
//   SCLK/CHIP_SELECT/MOSI/MISO are the SPI pins.
// Optional macro SPI_MASTER_BURST_EN: START in the last HOLD cycle chains the
// next word under the same CS-low window.
module spi_master_16
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    spi_master_16_if.master bus
);

    localparam int CNT_MAX = spi_max3(CLK_DIV, CS_SETUP, CS_HOLD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]         DIV_N     = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0]         SETUP_N   = CNT_W'(CS_SETUP);
    localparam logic [CNT_W-1:0]         HOLD_N    = CNT_W'(CS_HOLD);
    localparam logic [SPI_BIT_CNT_W-1:0] WORD_BITS = SPI_BIT_CNT_W'(SPI_WORD_W);

    spi_mst_state_t state_q, state_d;

    logic [SPI_WORD_W-1:0]    tx_shift_q, tx_shift_d;
    logic [SPI_WORD_W-1:0]    rx_shift_q, rx_shift_d;
    logic [SPI_WORD_W-1:0]    rx_data_q, rx_data_d;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic                     cs_q, cs_d;
    logic                     sclk_q, sclk_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             phase_end;

    spi_clk_div #(
        .W (CNT_W)
    ) u_clk_div (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (cnt_load),
        .load_val  (cnt_val),
        .phase_end (phase_end)
    );

    assign bit_cnt_inc = bit_cnt_q + SPI_BIT_CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = DIV_N;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    tx_shift_d = bus.TX_DATA;
                    bit_cnt_d  = '0;
                    cs_d       = 1'b0;
                    busy_d     = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_val    = SETUP_N;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    cnt_load = 1'b1;
                    state_d  = LOW;
                end
            end
            LOW: begin
                // MISO last moved on the previous SCLK fall, at least CLK_DIV
                // cycles ago, so it is safe to capture with the rising edge.
                if (phase_end) begin
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift_q[SPI_WORD_W-2:0], bus.MISO};
                    cnt_load   = 1'b1;
                    state_d    = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_inc;
                    cnt_load  = 1'b1;
                    if (bit_cnt_inc == WORD_BITS) begin
                        cnt_val = HOLD_N;
                        state_d = HOLD;
                    end else begin
                        // MOSI is tx_shift[MSB], so it only moves with SCLK falls.
                        tx_shift_d = {tx_shift_q[SPI_WORD_W-2:0], 1'b0};
                        state_d    = LOW;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                    cnt_load  = 1'b1;
`ifdef SPI_MASTER_BURST_EN
                    if (bus.START) begin
                        tx_shift_d = bus.TX_DATA;
                        bit_cnt_d  = '0;
                        cnt_val    = DIV_N;
                        state_d    = LOW;
                    end else begin
                        cs_d    = 1'b1;
                        cnt_val = HOLD_N;
                        state_d = GAP;
                    end
`else
                    cs_d    = 1'b1;
                    cnt_val = HOLD_N;
                    state_d = GAP;
`endif
                end
            end
            GAP: begin
                if (phase_end) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.CHIP_SELECT = cs_q;
    assign bus.SCLK        = sclk_q;
    assign bus.MOSI        = tx_shift_q[SPI_WORD_W-1];
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.RX_DATA     = rx_data_q;

endmodule

// File: tb/tb_spi_master_16.sv
// tb/tb_spi_master_16.sv - self-checking bench for spi_master_16 with a mode-0 slave model
module tb_spi_master_16;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    spi_master_16_if bus ();
    spi_master_16_if bus1 ();

    spi_master_16 #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    spi_master_16 #(
        .CLK_DIV  (1),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut1 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Reference model: what a correctly framed word must look like.
    typedef struct {
        int latency;
        int rises;
        int gap;
    } xfer_t;

    function automatic xfer_t model_xfer(input int div);
        xfer_t m;
        m.rises   = 16;
        m.latency = 1 + CS_SETUP + 2 * 16 * div + CS_HOLD;
        m.gap     = CS_HOLD;
        return m;
    endfunction

    // Mode-0 slave: samples MOSI on SCLK rise, shifts MISO on SCLK fall,
    // latches the word on every 16th fall while CS is low.
    logic [15:0] s_tx_words [4];
    logic [15:0] s_latched [$];
    logic [15:0] s_rx_sh   = '0;
    logic [15:0] s_tx_sh   = '0;
    int          s_rises   = 0;
    int          s_falls   = 0;
    int          s_idx     = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;

    always @(bus.SCLK or bus.CHIP_SELECT) begin
        if (prev_cs !== 1'b0 && bus.CHIP_SELECT === 1'b0) begin
            s_falls = 0;
            s_idx   = 0;
            s_tx_sh = s_tx_words[0];
        end
        if (bus.CHIP_SELECT !== 1'b0) begin
            s_falls = 0;
        end else if (prev_sclk === 1'b0 && bus.SCLK === 1'b1) begin
            s_rx_sh = {s_rx_sh[14:0], bus.MOSI};
            s_rises++;
        end else if (prev_sclk === 1'b1 && bus.SCLK === 1'b0) begin
            s_falls++;
            if (s_falls == 16) begin
                s_latched.push_back(s_rx_sh);
                s_falls = 0;
                s_idx++;
                s_tx_sh = (s_idx < 4) ? s_tx_words[s_idx] : 16'h0000;
            end else begin
                s_tx_sh = {s_tx_sh[14:0], 1'b0};
            end
        end
        prev_sclk = bus.SCLK;
        prev_cs   = bus.CHIP_SELECT;
        bus.MISO  = s_tx_sh[15];
    end

    function automatic logic [31:0] latched_at(input int idx);
        if (idx >= 0 && idx < s_latched.size()) return 32'(s_latched[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic run_word(input logic [15:0] tx, input logic [15:0] slv,
                            input logic [15:0] exp_slave, input logic [15:0] exp_rx,
                            input string tag);
        xfer_t m;
        int cyc;
        int n;
        int base_r;
        int base_l;
        m = model_xfer(CLK_DIV);
        s_tx_words[0] = slv;
        base_r = s_rises;
        base_l = s_latched.size();
        bus.START   = 1'b1;
        bus.TX_DATA = tx;
        tick();
        cyc = 1;
        bus.START   = 1'b0;
        bus.TX_DATA = 16'($urandom);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
        check({tag, "_cs_low"}, 32'(bus.CHIP_SELECT), 32'd0);
        check({tag, "_mosi_msb"}, 32'(bus.MOSI), 32'(tx[15]));
        while (bus.DONE !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, m.latency);
        check({tag, "_rx_data"}, 32'(bus.RX_DATA), 32'(exp_rx));
        check({tag, "_cs_high_at_done"}, 32'(bus.CHIP_SELECT), 32'd1);
        tick();
        n = 1;
        check({tag, "_done_one_cycle"}, 32'(bus.DONE), 32'd0);
        while (bus.BUSY !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_gap"}, n, m.gap);
        check({tag, "_rises"}, s_rises - base_r, m.rises);
        check({tag, "_words"}, s_latched.size() - base_l, 1);
        check({tag, "_slave_rx"}, latched_at(s_latched.size() - 1), 32'(exp_slave));
    endtask

    typedef struct {
        logic [15:0] tx;
        logic [15:0] slv;
        logic [15:0] exp_slave;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int          cyc;
        int          n;
        int          base_r;
        int          base_l;
        int          dones;
        int          breaks;
        int          rises;
        int          last_rise;
        int          bad_period;
        int          mosi_bad;
        int          exp_dones;
        logic        prev;
        logic [15:0] tx;
        logic [15:0] slv;

        vecs[0] = '{16'hA5C3, 16'h1234, 16'hA5C3, 16'h1234};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[3] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[4] = '{16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA};

        for (int i = 0; i < 4; i++) s_tx_words[i] = 16'h0000;
        bus.START    = 1'b0;
        bus.TX_DATA  = 16'h0000;
        bus1.START   = 1'b0;
        bus1.TX_DATA = 16'h0000;
        bus1.MISO    = 1'b0;

        // Reset held three cycles.
        RESET = 1'b1;
        repeat (3) tick();
        check("rst_cs", 32'(bus.CHIP_SELECT), 32'd1);
        check("rst_sclk", 32'(bus.SCLK), 32'd0);
        check("rst_mosi", 32'(bus.MOSI), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_rx", 32'(bus.RX_DATA), 32'd0);
        RESET = 1'b0;
        tick();

        // Table vectors back to back: each START lands in the cycle BUSY fell.
        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i].tx, vecs[i].slv, vecs[i].exp_slave, vecs[i].exp_rx,
                     $sformatf("vec%0d", i));
        end

        // Random words with random idle gaps.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            tx  = 16'($urandom);
            slv = 16'($urandom);
            run_word(tx, slv, tx, slv, $sformatf("rand%0d", i));
        end

        // START while busy is ignored and not queued.
        s_tx_words[0] = 16'h0F0F;
        base_r = s_rises;
        base_l = s_latched.size();
        bus.START   = 1'b1;
        bus.TX_DATA = 16'h00FF;
        tick();
        bus.START = 1'b0;
        repeat (9) tick();
        bus.START   = 1'b1;
        bus.TX_DATA = 16'hFF00;
        tick();
        bus.START = 1'b0;
        n = 0;
        while (bus.BUSY !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check("busy_ign_timeout", 32'(n < 400), 32'd1);
        repeat (10) tick();
        check("busy_ign_idle", 32'(bus.BUSY), 32'd0);
        check("busy_ign_rises", s_rises - base_r, 16);
        check("busy_ign_words", s_latched.size() - base_l, 1);
        check("busy_ign_slave_rx", latched_at(base_l), 32'h00FF);
        check("busy_ign_rx", 32'(bus.RX_DATA), 32'h0F0F);

        // Reset in the middle of a word.
        s_tx_words[0] = 16'h3C3C;
        base_r = s_rises;
        base_l = s_latched.size();
        bus.START   = 1'b1;
        bus.TX_DATA = 16'hDEAD;
        tick();
        bus.START = 1'b0;
        n = 0;
        while ((s_rises - base_r) < 5 && n < 200) begin
            tick();
            n++;
        end
        check("abort_wait", 32'(n < 200), 32'd1);
        RESET = 1'b1;
        tick();
        check("abort_cs", 32'(bus.CHIP_SELECT), 32'd1);
        check("abort_sclk", 32'(bus.SCLK), 32'd0);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_done", 32'(bus.DONE), 32'd0);
        check("abort_rx", 32'(bus.RX_DATA), 32'd0);
        RESET = 1'b0;
        dones = 0;
        repeat (10) begin
            if (bus.DONE === 1'b1) dones++;
            tick();
        end
        check("abort_no_done", dones, 0);
        check("abort_no_word", s_latched.size() - base_l, 0);
        run_word(16'hBEEF, 16'h4321, 16'hBEEF, 16'h4321, "after_abort");

        // CLK_DIV=1 boundary on the second instance, MISO tied low.
        bus1.START   = 1'b1;
        bus1.TX_DATA = 16'hFFFF;
        tick();
        cyc = 1;
        bus1.START   = 1'b0;
        bus1.TX_DATA = 16'h0000;
        prev       = 1'b0;
        rises      = 0;
        last_rise  = -1;
        bad_period = 0;
        mosi_bad   = 0;
        while (bus1.DONE !== 1'b1 && cyc < 200) begin
            if (bus1.CHIP_SELECT === 1'b0 && bus1.MOSI !== 1'b1) mosi_bad++;
            if (prev === 1'b0 && bus1.SCLK === 1'b1) begin
                if (last_rise >= 0 && (cyc - last_rise) != 2) bad_period++;
                last_rise = cyc;
                rises++;
            end
            prev = bus1.SCLK;
            tick();
            cyc++;
        end
        check("div1_latency", cyc, model_xfer(1).latency);
        check("div1_rises", rises, 16);
        check("div1_period", bad_period, 0);
        check("div1_mosi_const", mosi_bad, 0);
        check("div1_rx", 32'(bus1.RX_DATA), 32'h0000);
        n = 0;
        while (bus1.BUSY !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check("div1_gap", n, CS_HOLD);

        // START presented in the last HOLD cycle.
`ifdef SPI_MASTER_BURST_EN
        exp_dones = 2;
`else
        exp_dones = 1;
`endif
        s_tx_words[0] = 16'h0F0F;
        s_tx_words[1] = 16'hF0F0;
        base_r = s_rises;
        base_l = s_latched.size();
        bus.START   = 1'b1;
        bus.TX_DATA = 16'h0001;
        tick();
        cyc = 1;
        bus.START = 1'b0;
        while (cyc < CS_SETUP + 32 * CLK_DIV + CS_HOLD) begin
            tick();
            cyc++;
        end
        bus.START   = 1'b1;
        bus.TX_DATA = 16'h8000;
        tick();
        bus.START   = 1'b0;
        bus.TX_DATA = 16'h0000;
        dones  = 0;
        breaks = 0;
        n      = 0;
        while (bus.BUSY !== 1'b0 && n < 400) begin
            if (bus.DONE === 1'b1) dones++;
            if (bus.CHIP_SELECT === 1'b1 && dones < exp_dones) breaks++;
            tick();
            n++;
        end
        check("hold_start_timeout", 32'(n < 400), 32'd1);
        check("hold_start_dones", dones, exp_dones);
        check("hold_start_cs_breaks", breaks, 0);
        check("hold_start_rises", s_rises - base_r, 16 * exp_dones);
        check("hold_start_words", s_latched.size() - base_l, exp_dones);
        check("hold_start_word0", latched_at(base_l), 32'h0001);
`ifdef SPI_MASTER_BURST_EN
        check("burst_word1", latched_at(base_l + 1), 32'h8000);
        check("burst_rx", 32'(bus.RX_DATA), 32'hF0F0);
`else
        check("hold_start_rx", 32'(bus.RX_DATA), 32'h0F0F);
        repeat (10) tick();
        check("hold_start_not_queued", 32'(bus.BUSY), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
